// File: rtl/execute_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : execute_muldiv_ctrl
// Purpose  : Iterative RV32M multiply/divide sequencer for the execute stage.
//            It accepts one M-extension op, stalls the front of the pipeline
//            while it iterates for XLEN cycles, then presents the result for
//            a single cycle. Divide-by-zero and signed overflow finish on a
//            one-cycle fast path.
// Ports    : clk, rst (async, active-high)
//            Start_E, MulDivOp_E, SrcA_E, SrcB_E, Flush_E  <- execute stage
//            Stall_E                                       -> hazard unit
//            MulDivValid_M, MulDivResult_M                 -> EX/MEM boundary
//            Busy                                          -> status
// Revision : 1.0 - initial release
// ============================================================================
module execute_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start_E,
    input  logic [2:0]      MulDivOp_E,
    input  logic [XLEN-1:0] SrcA_E,
    input  logic [XLEN-1:0] SrcB_E,
    input  logic            Flush_E,
    output logic            Stall_E,
    output logic            MulDivValid_M,
    output logic [XLEN-1:0] MulDivResult_M,
    output logic            Busy
);

    localparam logic [1:0]       c_STATE_IDLE = 2'd0;
    localparam logic [1:0]       c_STATE_BUSY = 2'd1;
    localparam logic [1:0]       c_STATE_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST_ITER  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    // Mul: {r_hi,r_lo} is the product/multiplier pair, r_mcand = |A|.
    // Div: r_hi = partial remainder, r_lo = dividend/quotient, r_mcand = |B|.
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    // ---------------- operand decode at accept ----------------
    logic            w_isDiv, w_aSigned, w_bSigned, w_aNeg, w_bNeg, w_resNeg;
    logic [XLEN-1:0] w_absA, w_absB;
    logic            w_divByZero, w_overflow, w_fast, w_accept;
    logic [XLEN-1:0] w_fastResult;

    assign w_isDiv     = MulDivOp_E[2];
    assign w_aSigned   = (MulDivOp_E != 3'd3) && (MulDivOp_E != 3'd5) && (MulDivOp_E != 3'd7);
    assign w_bSigned   = (MulDivOp_E == 3'd0) || (MulDivOp_E == 3'd1) ||
                         (MulDivOp_E == 3'd4) || (MulDivOp_E == 3'd6);
    assign w_aNeg      = w_aSigned & SrcA_E[XLEN-1];
    assign w_bNeg      = w_bSigned & SrcB_E[XLEN-1];
    assign w_absA      = w_aNeg ? -SrcA_E : SrcA_E;
    assign w_absB      = w_bNeg ? -SrcB_E : SrcB_E;
    // Remainder takes the dividend's sign; everything else is the product of signs.
    assign w_resNeg    = (MulDivOp_E == 3'd6) ? w_aNeg : (w_aNeg ^ w_bNeg);

    assign w_divByZero = w_isDiv && (SrcB_E == '0);
    assign w_overflow  = w_isDiv && !MulDivOp_E[0] && (SrcA_E == c_INT_MIN) && (SrcB_E == '1);
    assign w_fast      = w_divByZero | w_overflow;
    // MulDivOp_E[1] distinguishes REM/REMU from DIV/DIVU.
    assign w_fastResult = w_divByZero ? (MulDivOp_E[1] ? SrcA_E : '1)
                                      : (MulDivOp_E[1] ? '0     : SrcA_E);

    assign w_accept    = (r_state == c_STATE_IDLE) && Start_E && !Flush_E;

    // ---------------- one iteration step ----------------
    logic [XLEN:0]   w_mulSum, w_divShift, w_divDiff;
    logic            w_divFits;
    logic [XLEN-1:0] w_stepHi, w_stepLo;

    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_divShift = {r_hi, r_lo[XLEN-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_mcand};
    assign w_divFits  = !w_divDiff[XLEN];

    assign w_stepHi = r_op[2] ? (w_divFits ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0])
                              : w_mulSum[XLEN:1];
    assign w_stepLo = r_op[2] ? {r_lo[XLEN-2:0], w_divFits}
                              : {w_mulSum[0], r_lo[XLEN-1:1]};

    // ---------------- result formatting after the last step ----------------
    logic [2*XLEN-1:0] w_prod, w_prodSigned;
    logic [XLEN-1:0]   w_quo, w_rem, w_finalResult;

    assign w_prod       = {w_stepHi, w_stepLo};
    assign w_prodSigned = r_neg ? -w_prod : w_prod;
    assign w_quo        = r_neg ? -w_stepLo : w_stepLo;
    assign w_rem        = r_neg ? -w_stepHi : w_stepHi;

    always_comb begin
        w_finalResult = '0;
        case (r_op)
            3'd0:                w_finalResult = w_prodSigned[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_finalResult = w_prodSigned[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_finalResult = w_quo;
            default:             w_finalResult = w_rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_STATE_IDLE: if (w_accept) w_nextState = w_fast ? c_STATE_DONE : c_STATE_BUSY;
            c_STATE_BUSY: begin
                if (Flush_E)                  w_nextState = c_STATE_IDLE;
                else if (r_cnt == c_LAST_ITER) w_nextState = c_STATE_DONE;
            end
            // New ops are never accepted here; the pipeline advances this cycle.
            c_STATE_DONE: w_nextState = c_STATE_IDLE;
            default:      w_nextState = c_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_STATE_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_op    <= MulDivOp_E;
                r_neg   <= w_resNeg;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_lo    <= w_isDiv ? w_absA : w_absB;
                r_mcand <= w_isDiv ? w_absB : w_absA;
                if (w_fast) begin
                    r_result <= w_fastResult;
                    r_valid  <= 1'b1;
                end
            end else if (r_state == c_STATE_BUSY) begin
                if (Flush_E) begin
                    r_cnt <= '0;
                end else begin
                    r_hi  <= w_stepHi;
                    r_lo  <= w_stepLo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_ITER) begin
                        r_cnt    <= '0;
                        r_result <= w_finalResult;
                        r_valid  <= 1'b1;
                    end
                end
            end
        end
    end

    assign Stall_E        = w_accept || (r_state == c_STATE_BUSY);
    assign Busy           = (r_state != c_STATE_IDLE);
    assign MulDivValid_M  = r_valid;
    assign MulDivResult_M = r_result;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_muldiv_ctrl
// Purpose  : Directed self-checking bench for execute_muldiv_ctrl with
//            hand-computed expected results, latencies and stall behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        Start_E;
    logic [2:0]  MulDivOp_E;
    logic [31:0] SrcA_E;
    logic [31:0] SrcB_E;
    logic        Flush_E;
    logic        Stall_E;
    logic        MulDivValid_M;
    logic [31:0] MulDivResult_M;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    execute_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .Start_E        (Start_E),
        .MulDivOp_E     (MulDivOp_E),
        .SrcA_E         (SrcA_E),
        .SrcB_E         (SrcB_E),
        .Flush_E        (Flush_E),
        .Stall_E        (Stall_E),
        .MulDivValid_M  (MulDivValid_M),
        .MulDivResult_M (MulDivResult_M),
        .Busy           (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op (caller sits 1ns after a rising edge) and reports timing.
    // lat = 1 means the result is valid in the cycle right after the accept edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int stallCyc,
                          output logic stallAtStart, output logic stallInDone,
                          output logic validAfter);
        Start_E = 1'b1; MulDivOp_E = op; SrcA_E = a; SrcB_E = b;
        #1 stallAtStart = Stall_E;
        @(posedge clk); #1;
        Start_E = 1'b0; SrcA_E = 32'hA5A5_A5A5; SrcB_E = 32'h5A5A_5A5A;
        lat = 1; stallCyc = 0;
        while (!MulDivValid_M && lat < 100) begin
            if (Stall_E) stallCyc++;
            @(posedge clk); #1;
            lat++;
        end
        res = MulDivResult_M;
        stallInDone = Stall_E;
        @(posedge clk); #1;
        validAfter = MulDivValid_M;
    endtask

    task automatic test_reset;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Stall_E !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall_E); end
        checks++; if (MulDivValid_M !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", MulDivValid_M); end
        checks++; if (MulDivResult_M !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", MulDivResult_M); end
    endtask

    task automatic test_mul;
        int lat, sc; logic [31:0] res; logic s0, sd, va;
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, lat, res, sc, s0, sd, va);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL mul_stall_t0: got %b expected 1", s0); end
        checks++; if (sc !== 32) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 32", sc); end
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_done: got %b expected 0", sd); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL mul_valid_pulse: got %b expected 0", va); end
        checks++; if (MulDivResult_M !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h expected ffffffeb", MulDivResult_M); end
    endtask

    task automatic test_mulh;
        logic [2:0]  ops [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] exps[3] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        int lat, sc; logic [31:0] res; logic s0, sd, va;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sc, s0, sd, va);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL mulh_op%0d_result: got %h expected %h", ops[i], res, exps[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_op%0d_latency: got %0d expected 33", ops[i], lat); end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat, sc; logic [31:0] res; logic s0, sd, va;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, sc, s0, sd, va);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL fast%0d_result: got %h expected %h", i, res, exps[i]); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL fast%0d_latency: got %0d expected 1", i, lat); end
            checks++; if (sc !== 0) begin errors++; $display("FAIL fast%0d_stall_cycles: got %0d expected 0", i, sc); end
        end
    endtask

    task automatic test_back_to_back;
        Start_E = 1'b1; MulDivOp_E = 3'd5; SrcA_E = 32'd5; SrcB_E = 32'd0;
        @(posedge clk); #1;
        checks++; if (MulDivValid_M !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b expected 1", MulDivValid_M); end
        checks++; if (Stall_E !== 1'b0) begin errors++; $display("FAIL b2b_stall_done: got %b expected 0", Stall_E); end
        @(posedge clk); #1;
        checks++; if (MulDivValid_M !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b expected 0", MulDivValid_M); end
        checks++; if (Stall_E !== 1'b1) begin errors++; $display("FAIL b2b_gap_stall: got %b expected 1", Stall_E); end
        @(posedge clk); #1;
        Start_E = 1'b0;
        checks++; if (MulDivValid_M !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b expected 1", MulDivValid_M); end
        @(posedge clk); #1;
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat, sc; logic [31:0] res; logic s0, sd, va;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, sc, s0, sd, va);
            checks++; if (res !== exps[i]) begin errors++; $display("FAIL div%0d_result: got %h expected %h", i, res, exps[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL div%0d_latency: got %0d expected 33", i, lat); end
        end
    endtask

    // Expects the previous op to have been REMU 100/7 (result register = 2).
    task automatic test_flush;
        int lat, sc; logic [31:0] res; logic s0, sd, va; logic sawValid;
        Start_E = 1'b1; MulDivOp_E = 3'd4; SrcA_E = 32'hFFFF_FFF9; SrcB_E = 32'd2;
        @(posedge clk); #1;
        Start_E = 1'b0;
        repeat (9) @(posedge clk);
        #1 Flush_E = 1'b1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", Busy); end
        @(posedge clk); #1;
        Flush_E = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", Busy); end
        checks++; if (Stall_E !== 1'b0) begin errors++; $display("FAIL flush_stall_after: got %b expected 0", Stall_E); end
        sawValid = 1'b0;
        repeat (40) begin
            if (MulDivValid_M) sawValid = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (sawValid !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", sawValid); end
        checks++; if (MulDivResult_M !== 32'd2) begin errors++; $display("FAIL flush_result_kept: got %h expected 00000002", MulDivResult_M); end
        run_op(3'd0, 32'd3, 32'd4, lat, res, sc, s0, sd, va);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL flush_next_mul_result: got %h expected 0000000c", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL flush_next_mul_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_async_reset;
        int lat, sc; logic [31:0] res; logic s0, sd, va;
        Start_E = 1'b1; MulDivOp_E = 3'd0; SrcA_E = 32'd5; SrcB_E = 32'd6;
        @(posedge clk); #1;
        Start_E = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", Busy); end
        checks++; if (Stall_E !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b expected 0", Stall_E); end
        checks++; if (MulDivValid_M !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", MulDivValid_M); end
        checks++; if (MulDivResult_M !== 32'h0) begin errors++; $display("FAIL arst_result: got %h expected 00000000", MulDivResult_M); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, lat, res, sc, s0, sd, va);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL arst_recover_result: got %h expected 0000000e", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL arst_recover_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        rst = 1'b1; Start_E = 1'b0; MulDivOp_E = 3'd0; SrcA_E = '0; SrcB_E = '0; Flush_E = 1'b0;
        #12;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_mul;
        test_mulh;
        test_fast_path;
        test_back_to_back;
        test_div;
        test_flush;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
